// File: rtl/sid_write_queue.sv
// sid_write_queue: decodes two-byte SPI register writes, queues them, and releases one per CLKen.
// Ports: CLK/RSTn clock and async active-low reset; RX_DATA/RX_VALID SPI byte stream;
// CLKen 1 MHz SID enable; CLEAR clears sticky flags; WR/ADDR/DATAW SID write bus;
// LEVEL queue occupancy; OVERFLOW dropped-write flag; FRAME_ERR protocol-violation flag.
module sid_write_queue #(
   parameter int DEPTH = 16,
   parameter int LW = $clog2(DEPTH) + 1
) (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic [7:0]    RX_DATA,
   input  logic          RX_VALID,
   input  logic          CLKen,
   input  logic          CLEAR,
   output logic          WR,
   output logic [4:0]    ADDR,
   output logic [7:0]    DATAW,
   output logic [LW-1:0] LEVEL,
   output logic          OVERFLOW,
   output logic          FRAME_ERR
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {IDLE, HAVE_HDR} state_t;
   state_t state;
   logic [4:0] hdr_addr;
   logic [1:0] hdr_msb;
   logic [AW-1:0] rptr, wptr;
   logic [12:0] mem [DEPTH];
   logic is_hdr, push, pop, full, accept, drop, frame_bad;
   assign is_hdr = RX_DATA[7];
   assign push = RX_VALID && state == HAVE_HDR && !is_hdr;
   // pop looks only at the registered LEVEL, so a same-cycle push into an empty queue waits
   assign pop = CLKen && LEVEL != '0;
   assign full = LEVEL == LW'(DEPTH);
   // a full queue still accepts when the head leaves in the same cycle
   assign accept = push && (!full || pop);
   assign drop = push && full && !pop;
   assign frame_bad = RX_VALID && (state == IDLE ? !is_hdr : is_hdr);
   always_ff @(posedge CLK) begin
      if (accept) mem[wptr] <= {hdr_addr, hdr_msb, RX_DATA[5:0]};
   end
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= IDLE;
         hdr_addr <= '0;
         hdr_msb <= '0;
         rptr <= '0;
         wptr <= '0;
         LEVEL <= '0;
         WR <= 1'b0;
         ADDR <= '0;
         DATAW <= '0;
         OVERFLOW <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         if (RX_VALID) begin
            if (is_hdr) begin
               hdr_addr <= RX_DATA[6:2];
               hdr_msb <= RX_DATA[1:0];
               state <= HAVE_HDR;
            end else state <= IDLE;
         end
         if (accept) wptr <= wptr + AW'(1);
         if (pop) begin
            rptr <= rptr + AW'(1);
            {ADDR, DATAW} <= mem[rptr];
         end
         WR <= pop;
         LEVEL <= LEVEL + LW'(accept) - LW'(pop);
         // set has priority over CLEAR
         OVERFLOW <= drop | (OVERFLOW & ~CLEAR);
         FRAME_ERR <= frame_bad | (FRAME_ERR & ~CLEAR);
      end
   end
endmodule

// File: tb/tb_sid_write_queue.sv
// tb_sid_write_queue: directed scenario bench for sid_write_queue.
module tb_sid_write_queue;
   logic CLK = 0, RSTn = 0, RX_VALID = 0, CLEAR = 0;
   logic [7:0] RX_DATA = 0;
   logic CLKen, WR, OVERFLOW, FRAME_ERR;
   logic [4:0] ADDR, LEVEL;
   logic [7:0] DATAW;
   logic ken_run = 0, ken_tick = 0, ken_force = 0, ken_prev = 0, wr_prev = 0;
   int div = 0, cyc = 0, compared = 0, mismatched = 0;
   logic [12:0] wq[$];
   int wc[$];
   assign CLKen = ken_run ? ken_tick : ken_force;
   sid_write_queue dut (
      .CLK(CLK), .RSTn(RSTn), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .CLKen(CLKen),
      .CLEAR(CLEAR), .WR(WR), .ADDR(ADDR), .DATAW(DATAW), .LEVEL(LEVEL),
      .OVERFLOW(OVERFLOW), .FRAME_ERR(FRAME_ERR)
   );
   always #5 CLK = ~CLK;
   always begin
      @(posedge CLK);
      #2;
      if (!ken_run) begin
         div = 0;
         ken_tick = 0;
      end else begin
         ken_tick = (div == 11);
         div = (div == 11) ? 0 : div + 1;
      end
   end
   always @(negedge CLK) begin
      cyc++;
      if (WR) begin
         compared++;
         if (!ken_prev || wr_prev) begin
            mismatched++;
            $display("FAIL wr_timing: prev CLKen=%b prev WR=%b, required 1/0", ken_prev, wr_prev);
         end
         wq.push_back({ADDR, DATAW});
         wc.push_back(cyc);
      end
      ken_prev = CLKen;
      wr_prev = WR;
   end
   function automatic logic [12:0] fr(int i);
      fr = {5'(i * 7 + 2), 8'(i * 53 + 17)};
   endfunction
   task automatic step();
      @(posedge CLK);
      #2;
   endtask
   task automatic send_byte(input logic [7:0] b);
      step();
      RX_DATA = b;
      RX_VALID = 1;
      step();
      RX_VALID = 0;
   endtask
   task automatic send_frame(input logic [12:0] e);
      send_byte({1'b1, e[12:8], e[7:6]});
      send_byte({2'b00, e[5:0]});
   endtask
   task automatic wait_writes(input int k, input int lim);
      for (int i = 0; i < lim && wq.size() < k; i++) @(negedge CLK);
      repeat (14) @(negedge CLK);
   endtask
   task automatic pulse_clear();
      step();
      CLEAR = 1;
      step();
      CLEAR = 0;
      @(negedge CLK);
   endtask
   task automatic test_reset();
      @(negedge CLK);
      compared++;
      if ({WR, ADDR, DATAW, LEVEL, OVERFLOW, FRAME_ERR} !== 21'd0) begin
         mismatched++;
         $display("FAIL reset_state: got %h required 0", {WR, ADDR, DATAW, LEVEL, OVERFLOW, FRAME_ERR});
      end
      step();
      RSTn = 1;
   endtask
   task automatic test_single();
      ken_run = 0; wq.delete(); wc.delete();
      send_frame({5'h18, 8'hCF});
      @(negedge CLK);
      compared++;
      if (LEVEL !== 5'd1) begin mismatched++; $display("FAIL single_level: got %0d required 1", LEVEL); end
      ken_run = 1;
      wait_writes(1, 40);
      compared++;
      if (wq.size() !== 1) begin mismatched++; $display("FAIL single_count: got %0d required 1", wq.size()); end
      compared++;
      if (wq[0] !== {5'h18, 8'hCF}) begin mismatched++; $display("FAIL single_entry: got %h required %h", wq[0], {5'h18, 8'hCF}); end
      compared++;
      if ({ADDR, DATAW, LEVEL} !== {5'h18, 8'hCF, 5'd0}) begin
         mismatched++;
         $display("FAIL single_hold: got addr=%h data=%h level=%0d required 18/cf/0", ADDR, DATAW, LEVEL);
      end
   endtask
   task automatic test_back_to_back();
      ken_run = 0; wq.delete(); wc.delete();
      for (int i = 0; i < 5; i++) send_frame(fr(i));
      @(negedge CLK);
      compared++;
      if (LEVEL !== 5'd5) begin mismatched++; $display("FAIL burst_level: got %0d required 5", LEVEL); end
      ken_run = 1;
      wait_writes(5, 100);
      compared++;
      if (wq.size() !== 5) begin mismatched++; $display("FAIL burst_count: got %0d required 5", wq.size()); end
      for (int i = 0; i < 5 && i < wq.size(); i++) begin
         compared++;
         if (wq[i] !== fr(i)) begin mismatched++; $display("FAIL burst_entry%0d: got %h required %h", i, wq[i], fr(i)); end
         if (i > 0) begin
            compared++;
            if (wc[i] - wc[i-1] !== 12) begin mismatched++; $display("FAIL burst_gap%0d: got %0d required 12", i, wc[i] - wc[i-1]); end
         end
      end
   endtask
   task automatic test_overflow_wrap();
      ken_run = 0; wq.delete(); wc.delete();
      for (int i = 0; i < 18; i++) send_frame(fr(i + 10));
      @(negedge CLK);
      compared++;
      if ({LEVEL, OVERFLOW} !== {5'd16, 1'b1}) begin mismatched++; $display("FAIL ovf_full: got level=%0d ovf=%b required 16/1", LEVEL, OVERFLOW); end
      ken_run = 1;
      wait_writes(16, 16 * 12 + 30);
      repeat (30) @(negedge CLK);
      compared++;
      if (wq.size() !== 16) begin mismatched++; $display("FAIL ovf_count: got %0d required 16", wq.size()); end
      for (int i = 0; i < 16 && i < wq.size(); i++) begin
         compared++;
         if (wq[i] !== fr(i + 10)) begin mismatched++; $display("FAIL ovf_entry%0d: got %h required %h", i, wq[i], fr(i + 10)); end
      end
      compared++;
      if (LEVEL !== 5'd0) begin mismatched++; $display("FAIL ovf_drained: got %0d required 0", LEVEL); end
      pulse_clear();
      compared++;
      if (OVERFLOW !== 1'b0) begin mismatched++; $display("FAIL ovf_clear: got %b required 0", OVERFLOW); end
   endtask
   task automatic test_framing();
      ken_run = 0; wq.delete(); wc.delete();
      send_byte(8'h05);
      @(negedge CLK);
      compared++;
      if ({FRAME_ERR, LEVEL} !== {1'b1, 5'd0}) begin mismatched++; $display("FAIL frame_lone: got err=%b level=%0d required 1/0", FRAME_ERR, LEVEL); end
      send_byte(8'h8D);
      send_byte(8'hF6);
      send_byte(8'h6A);
      @(negedge CLK);
      compared++;
      if (LEVEL !== 5'd1) begin mismatched++; $display("FAIL frame_level: got %0d required 1", LEVEL); end
      ken_run = 1;
      wait_writes(1, 40);
      compared++;
      if (wq.size() !== 1 || wq[0] !== {5'h1D, 8'hAA}) begin
         mismatched++;
         $display("FAIL frame_entry: got n=%0d %h required 1 %h", wq.size(), wq[0], {5'h1D, 8'hAA});
      end
      compared++;
      if (FRAME_ERR !== 1'b1) begin mismatched++; $display("FAIL frame_sticky: got %b required 1", FRAME_ERR); end
      pulse_clear();
      compared++;
      if (FRAME_ERR !== 1'b0) begin mismatched++; $display("FAIL frame_clear: got %b required 0", FRAME_ERR); end
   endtask
   task automatic test_simultaneous();
      logic [12:0] e;
      ken_run = 0; wq.delete(); wc.delete();
      for (int i = 0; i < 16; i++) send_frame(fr(i + 40));
      e = fr(99);
      send_byte({1'b1, e[12:8], e[7:6]});
      step();
      RX_DATA = {2'b00, e[5:0]}; RX_VALID = 1; ken_force = 1;
      step();
      RX_VALID = 0; ken_force = 0;
      @(negedge CLK);
      @(negedge CLK);
      compared++;
      if ({LEVEL, OVERFLOW} !== {5'd16, 1'b0}) begin mismatched++; $display("FAIL sim_pushpop: got level=%0d ovf=%b required 16/0", LEVEL, OVERFLOW); end
      compared++;
      if (wq.size() !== 1 || wq[0] !== fr(40)) begin mismatched++; $display("FAIL sim_pop: got n=%0d %h required 1 %h", wq.size(), wq[0], fr(40)); end
      e = fr(100);
      send_byte({1'b1, e[12:8], e[7:6]});
      step();
      RX_DATA = {2'b00, e[5:0]}; RX_VALID = 1; CLEAR = 1;
      step();
      RX_VALID = 0; CLEAR = 0;
      @(negedge CLK);
      compared++;
      if ({LEVEL, OVERFLOW} !== {5'd16, 1'b1}) begin mismatched++; $display("FAIL sim_clear_ovf: got level=%0d ovf=%b required 16/1", LEVEL, OVERFLOW); end
      ken_run = 1;
      wait_writes(17, 17 * 12 + 40);
      compared++;
      if (wq.size() !== 17 || wq[16] !== fr(99) || LEVEL !== 5'd0) begin
         mismatched++;
         $display("FAIL sim_drain: got n=%0d last=%h level=%0d required 17 %h 0", wq.size(), wq[16], LEVEL, fr(99));
      end
   endtask
   task automatic test_reset_mid();
      logic [12:0] e;
      ken_run = 0; wq.delete(); wc.delete();
      for (int i = 0; i < 3; i++) send_frame(fr(i + 60));
      e = fr(70);
      send_byte({1'b1, e[12:8], e[7:6]});
      @(negedge CLK);
      compared++;
      if ({LEVEL, OVERFLOW} !== {5'd3, 1'b1}) begin mismatched++; $display("FAIL rst_pre: got level=%0d ovf=%b required 3/1", LEVEL, OVERFLOW); end
      step();
      RSTn = 0;
      #1;
      compared++;
      if ({WR, ADDR, DATAW, LEVEL, OVERFLOW, FRAME_ERR} !== 21'd0) begin
         mismatched++;
         $display("FAIL rst_async: got %h required 0", {WR, ADDR, DATAW, LEVEL, OVERFLOW, FRAME_ERR});
      end
      repeat (3) step();
      RSTn = 1;
      ken_run = 1;
      send_byte({2'b00, e[5:0]});
      @(negedge CLK);
      compared++;
      if ({FRAME_ERR, LEVEL} !== {1'b1, 5'd0}) begin mismatched++; $display("FAIL rst_lone: got err=%b level=%0d required 1/0", FRAME_ERR, LEVEL); end
      repeat (40) @(negedge CLK);
      compared++;
      if (wq.size() !== 0 || LEVEL !== 5'd0) begin mismatched++; $display("FAIL rst_nowr: got n=%0d level=%0d required 0/0", wq.size(), LEVEL); end
   endtask
   initial begin
      repeat (3) step();
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow_wrap();
      test_framing();
      test_simultaneous();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/sid_write_queue.md
# sid_write_queue

Upstream stage of the SID core. Decodes the two-byte SPI register-write protocol from the SPI slave byte stream, buffers complete writes in a FIFO, and releases them to the SID bus at most once per 1 MHz CLKen period. Host bursts therefore never collide with or outrun the SID write timing. Framing errors and overflow are reported as sticky flags.

## Interface

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- LW, $clog2(DEPTH)+1: width of LEVEL (derived).

Ports:
- CLK, in, 1: 12 MHz system clock.
- RSTn, in, 1: reset. One clock; reset is asynchronous and active-low.
- RX_DATA, in, 8: byte from the SPI slave.
- RX_VALID, in, 1: one-CLK strobe; RX_DATA is valid in that cycle.
- CLKen, in, 1: SID 1 MHz enable, one CLK wide.
- CLEAR, in, 1: synchronous clear of the sticky flags.
- WR, out, 1: one-CLK write strobe to the SID.
- ADDR, out, 5: SID register address. Held between writes.
- DATAW, out, 8: SID write data. Held between writes.
- LEVEL, out, LW: FIFO occupancy, 0..DEPTH.
- OVERFLOW, out, 1: sticky; set when a complete write is dropped because the FIFO is full.
- FRAME_ERR, out, 1: sticky; set on a protocol sequence violation.

## Operation

Byte format:
- Header byte 1AAA AADD: address = byte[6:2], data[7:6] = byte[1:0].
- Data byte 0xDD DDDD: data[5:0] = byte[5:0]; byte[6] is ignored.

Decoder FSM (acts only on RX_VALID cycles):
- IDLE + header: latch addr and data MSBs; go to HAVE_HDR.
- IDLE + data byte: discard it; set FRAME_ERR; stay in IDLE.
- HAVE_HDR + data byte: push the 13-bit entry {addr, hdr[1:0], byte[5:0]}; go to IDLE.
- HAVE_HDR + header: overwrite the latched header; set FRAME_ERR; stay in HAVE_HDR.

FIFO:
- Circular buffer with a read pointer, a write pointer and a count. Pointers wrap modulo DEPTH.
- Push when full with no pop in the same cycle: entry dropped, pointers unchanged, OVERFLOW set.
- Push and pop in the same cycle, including when full: both happen and LEVEL is unchanged.
- A pop is decided from the registered LEVEL. A push into an empty FIFO cannot be popped in the same cycle.

Drain:
- In a cycle with CLKen=1 and LEVEL>0: pop the head entry.
- Next cycle: ADDR and DATAW take the popped entry and WR=1 for exactly one CLK.
- At most one pop per CLKen pulse.

Flags:
- CLEAR=1 zeroes OVERFLOW and FRAME_ERR.
- If a set event occurs in the same cycle as CLEAR, set wins.

## Timing

- Reset (RSTn low, asynchronous): WR=0, ADDR=0, DATAW=0, LEVEL=0, OVERFLOW=0, FRAME_ERR=0, FSM=IDLE, latched header=0, pointers=0.
- Reset mid-frame discards the partial header and all queued entries. No WR is issued after release until a new complete frame arrives.
- Data-byte strobe in cycle t: LEVEL increments at t+1.
- Pop at the first CLKen cycle c ≥ t+1 in which LEVEL>0. WR, ADDR and DATAW are visible at c+1. With CLKen every 12 CLKs, worst-case write latency is 13 CLKs plus queueing.
- Sustained drain rate: one write per CLKen period. LEVEL decrements at c+1.
- WR is never asserted on two consecutive cycles.
- WR is registered; there is no combinational path from inputs to outputs.

## Test plan

- Single write: send 0x80|(0x18<<2)|0x3 then 0x0F with CLKen every 12 CLKs. Expect exactly one WR with ADDR=0x18, DATAW=0xCF, one cycle after the next CLKen; LEVEL returns to 0.
- Burst and pacing: push 5 frames back-to-back. Expect LEVEL=5 after the last push and 5 WR pulses spaced exactly 12 CLKs apart, in push order.
- Overflow and wrap: with DEPTH=16 and CLKen held low, push 18 frames. Expect LEVEL=16 and OVERFLOW=1. Enable CLKen: the first 16 entries drain in order through the pointer wrap, and entries 17-18 never appear.
- Framing: send data byte 0x05 in IDLE, then header H1, header H2, data D. Expect FRAME_ERR=1 and a single write using H2's address and MSBs. Pulse CLEAR: FRAME_ERR=0.
- Simultaneous events: with a full FIFO, a push coincides with a CLKen pop; expect LEVEL stays 16 and OVERFLOW stays 0. CLEAR coincides with a new overflow; expect OVERFLOW=1.
- Reset mid-operation: assert RSTn low between the header and data bytes with LEVEL=3. Expect all outputs 0 immediately. After release, a lone data byte sets FRAME_ERR and no WR occurs.
